spi_cs_sequencer: RTL and testbench



---
 rtl/spi_cs_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_cs_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cs_sequencer.sv
// Byte-stream front end for the SPI_Master engine: TX FIFO, RX buffer and chip-select sequencing.
// Define SPI_SEQ_RX_FIFO_EN for a DEPTH-entry RX FIFO; otherwise RX is a single holding register.
module spi_cs_sequencer #(
    parameter int DEPTH         = 8,
    parameter int CS_SETUP_CLKS = 4,
    parameter int CS_HOLD_CLKS  = 4,
    parameter int CS_GAP_CLKS   = 2
) (
    input  logic                   i_Clk,
    input  logic                   rstn,
    input  logic                   i_Wr_En,
    input  logic [7:0]             i_Wr_Data,
    output logic                   o_Tx_Full,
    output logic [$clog2(DEPTH):0] o_Tx_Count,
    input  logic                   i_Rd_En,
    output logic [7:0]             o_Rd_Data,
    output logic                   o_Rx_Empty,
    output logic                   o_Rx_Ovf,
    input  logic                   i_Clr_Ovf,
    input  logic                   i_Hold_CS,
    output logic                   o_Busy,
    output logic                   o_Done,
    output logic [7:0]             o_TX_Byte,
    output logic                   o_TX_DV,
    input  logic                   i_TX_Ready,
    input  logic                   i_RX_DV,
    input  logic [7:0]             i_RX_Byte,
    output logic                   o_SPI_CS_n
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_WAIT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t        r_state;
    logic [7:0]    r_cnt;
    logic          r_hold_armed;
    logic          r_cs_n;
    logic          r_tx_dv;
    logic [7:0]    r_tx_byte;
    logic          r_done;

    logic [7:0]    r_tx_mem [DEPTH];
    logic [AW-1:0] r_tx_wr_ptr;
    logic [AW-1:0] r_tx_rd_ptr;
    logic [CW-1:0] r_tx_count;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic          w_tx_push;
    logic          w_tx_pop;

    assign w_tx_full  = (r_tx_count == CW'(DEPTH));
    assign w_tx_empty = (r_tx_count == '0);
    assign w_tx_push  = i_Wr_En && !w_tx_full;
    assign w_tx_pop   = (r_state == S_LOAD) && i_TX_Ready && !w_tx_empty;

    // NOTE: the storage array has no reset; pointers and count define validity,
    // and resetting it would only cost a reset fan-out to every entry.
    always_ff @(posedge i_Clk) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wr_ptr] <= i_Wr_Data;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (!rstn) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
        end else begin
            if (w_tx_push)
                r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
            if (w_tx_pop)
                r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    logic r_rx_ovf;

`ifdef SPI_SEQ_RX_FIFO_EN
    logic [7:0]    r_rx_mem [DEPTH];
    logic [AW-1:0] r_rx_wr_ptr;
    logic [AW-1:0] r_rx_rd_ptr;
    logic [CW-1:0] r_rx_count;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic          w_rx_push;
    logic          w_rx_pop;

    assign w_rx_full  = (r_rx_count == CW'(DEPTH));
    assign w_rx_empty = (r_rx_count == '0);
    assign w_rx_push  = i_RX_DV && !w_rx_full;
    assign w_rx_pop   = i_Rd_En && !w_rx_empty;

    always_ff @(posedge i_Clk) begin
        if (w_rx_push)
            r_rx_mem[r_rx_wr_ptr] <= i_RX_Byte;
    end

    always_ff @(posedge i_Clk) begin
        if (!rstn) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
            r_rx_ovf    <= 1'b0;
        end else begin
            if (w_rx_push)
                r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
            if (w_rx_pop)
                r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: r_rx_count <= r_rx_count;
            endcase
            // A fresh overflow outranks a simultaneous clear.
            if (i_RX_DV && w_rx_full)
                r_rx_ovf <= 1'b1;
            else if (i_Clr_Ovf)
                r_rx_ovf <= 1'b0;
        end
    end

    assign o_Rx_Empty = w_rx_empty;
    assign o_Rd_Data  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd_ptr];
`else
    logic [7:0] r_rx_hold;
    logic       r_rx_empty;

    always_ff @(posedge i_Clk) begin
        if (!rstn) begin
            r_rx_hold  <= 8'h00;
            r_rx_empty <= 1'b1;
            r_rx_ovf   <= 1'b0;
        end else begin
            if (i_RX_DV) begin
                r_rx_hold  <= i_RX_Byte;
                r_rx_empty <= 1'b0;
            end else if (i_Rd_En) begin
                r_rx_empty <= 1'b1;
            end
            if (i_RX_DV && !r_rx_empty)
                r_rx_ovf <= 1'b1;
            else if (i_Clr_Ovf)
                r_rx_ovf <= 1'b0;
        end
    end

    assign o_Rx_Empty = r_rx_empty;
    assign o_Rd_Data  = r_rx_hold;
`endif

    always_ff @(posedge i_Clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_hold_armed <= 1'b0;
            r_cs_n       <= 1'b1;
            r_tx_dv      <= 1'b0;
            r_tx_byte    <= 8'h00;
            r_done       <= 1'b0;
        end else begin
            r_tx_dv <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_tx_empty) begin
                        r_cs_n  <= 1'b0;
                        r_cnt   <= 8'(CS_SETUP_CLKS);
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == 8'd1)
                        r_state <= S_LOAD;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                S_LOAD: begin
                    if (w_tx_pop) begin
                        r_tx_byte <= r_tx_mem[r_tx_rd_ptr];
                        r_tx_dv   <= 1'b1;
                        r_state   <= S_WAIT;
                    end else if (w_tx_empty && !i_Hold_CS) begin
                        r_cnt        <= 8'(CS_HOLD_CLKS);
                        r_hold_armed <= 1'b0;
                        r_state      <= S_HOLD;
                    end
                end
                S_WAIT: begin
                    if (i_RX_DV)
                        r_state <= S_LOAD;
                end
                S_HOLD: begin
                    // Hold count starts once the engine reports idle, covering its SCLK output lag.
                    if (r_hold_armed || i_TX_Ready) begin
                        r_hold_armed <= 1'b1;
                        if (r_cnt == 8'd1) begin
                            r_cs_n  <= 1'b1;
                            r_done  <= 1'b1;
                            r_cnt   <= 8'(CS_GAP_CLKS);
                            r_state <= S_GAP;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt == 8'd1)
                        r_state <= S_IDLE;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                default: begin
                    r_cs_n  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Tx_Full  = w_tx_full;
    assign o_Tx_Count = r_tx_count;
    assign o_Rx_Ovf   = r_rx_ovf;
    assign o_Busy     = (r_state != S_IDLE);
    assign o_Done     = r_done;
    assign o_TX_Byte  = r_tx_byte;
    assign o_TX_DV    = r_tx_dv;
    assign o_SPI_CS_n = r_cs_n;

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Directed self-checking bench for spi_cs_sequencer with a cycle-level SPI_Master loopback model.
// Covers both RX builds (SPI_SEQ_RX_FIFO_EN defined or not).
module tb_spi_cs_sequencer;

    localparam int DEPTH    = 8;
    localparam int SETUP    = 4;
    localparam int HOLD     = 4;
    localparam int GAP      = 2;
    localparam int BIT_CLKS = 20;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          i_Clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_Wr_En = 1'b0;
    logic [7:0]    i_Wr_Data = 8'h00;
    logic          o_Tx_Full;
    logic [CW-1:0] o_Tx_Count;
    logic          i_Rd_En = 1'b0;
    logic [7:0]    o_Rd_Data;
    logic          o_Rx_Empty;
    logic          o_Rx_Ovf;
    logic          i_Clr_Ovf = 1'b0;
    logic          i_Hold_CS = 1'b0;
    logic          o_Busy;
    logic          o_Done;
    logic [7:0]    o_TX_Byte;
    logic          o_TX_DV;
    logic          i_TX_Ready;
    logic          i_RX_DV;
    logic [7:0]    i_RX_Byte;
    logic          o_SPI_CS_n;

    spi_cs_sequencer #(
        .DEPTH(DEPTH), .CS_SETUP_CLKS(SETUP), .CS_HOLD_CLKS(HOLD), .CS_GAP_CLKS(GAP)
    ) dut (
        .i_Clk(i_Clk), .rstn(rstn),
        .i_Wr_En(i_Wr_En), .i_Wr_Data(i_Wr_Data), .o_Tx_Full(o_Tx_Full), .o_Tx_Count(o_Tx_Count),
        .i_Rd_En(i_Rd_En), .o_Rd_Data(o_Rd_Data), .o_Rx_Empty(o_Rx_Empty), .o_Rx_Ovf(o_Rx_Ovf),
        .i_Clr_Ovf(i_Clr_Ovf), .i_Hold_CS(i_Hold_CS), .o_Busy(o_Busy), .o_Done(o_Done),
        .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV), .i_TX_Ready(i_TX_Ready),
        .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte), .o_SPI_CS_n(o_SPI_CS_n)
    );

    always #5 i_Clk = ~i_Clk;

    int cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled 1 ns after each rising edge.
    int   dv_cnt = 0, done_cnt = 0, fall_cnt = 0, rise_cnt = 0, bad_done = 0;
    int   t_fall = 0, t_rise = 0, t_dv_first = 0, t_dv_last = 0;
    logic prev_cs = 1'b1;
    bit   dv_since_fall = 1'b0;

    initial forever begin
        @(posedge i_Clk);
        #1;
        if (prev_cs === 1'b1 && o_SPI_CS_n === 1'b0) begin
            fall_cnt++;
            t_fall = cyc;
            dv_since_fall = 1'b0;
        end
        if (prev_cs === 1'b0 && o_SPI_CS_n === 1'b1) begin
            rise_cnt++;
            t_rise = cyc;
        end
        if (o_TX_DV === 1'b1) begin
            dv_cnt++;
            t_dv_last = cyc;
            if (!dv_since_fall) begin
                t_dv_first = cyc;
                dv_since_fall = 1'b1;
            end
        end
        if (o_Done === 1'b1) begin
            done_cnt++;
            if (!(prev_cs === 1'b0 && o_SPI_CS_n === 1'b1))
                bad_done++;
        end
        prev_cs = o_SPI_CS_n;
    end

    // Engine model: MISO looped back to MOSI, RX_DV near the end of the byte, Ready one cycle later.
    logic       eng_stall = 1'b0;
    int         eng_cnt = 0;
    int         viol = 0;
    logic [7:0] eng_byte = 8'h00;
    logic [7:0] tx_log[$];
    int         rxdv_t[$];

    initial begin
        i_TX_Ready = 1'b1;
        i_RX_DV    = 1'b0;
        i_RX_Byte  = 8'h00;
        forever begin
            @(negedge i_Clk);
            if (!rstn) begin
                eng_cnt    = 0;
                i_RX_DV    = 1'b0;
                i_TX_Ready = !eng_stall;
            end else begin
                if (o_TX_DV === 1'b1 && (eng_cnt != 0 || !i_TX_Ready))
                    viol++;
                if (eng_cnt == 0) begin
                    i_RX_DV = 1'b0;
                    if (o_TX_DV === 1'b1) begin
                        eng_byte = o_TX_Byte;
                        tx_log.push_back(o_TX_Byte);
                        eng_cnt    = BIT_CLKS;
                        i_TX_Ready = 1'b0;
                    end else begin
                        i_TX_Ready = !eng_stall;
                    end
                end else if (eng_cnt == 2) begin
                    i_RX_DV   = 1'b1;
                    i_RX_Byte = eng_byte;
                    rxdv_t.push_back(cyc);
                    eng_cnt = 1;
                end else if (eng_cnt == 1) begin
                    i_RX_DV    = 1'b0;
                    i_TX_Ready = !eng_stall;
                    eng_cnt    = 0;
                end else begin
                    eng_cnt--;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        i_Wr_En   = 1'b1;
        i_Wr_Data = b;
        @(negedge i_Clk);
        i_Wr_En = 1'b0;
    endtask

    task automatic read_byte();
        i_Rd_En = 1'b1;
        @(negedge i_Clk);
        i_Rd_En = 1'b0;
    endtask

    task automatic wait_rx(input string tag);
        int n = 0;
        while (o_Rx_Empty !== 1'b0 && n < 200) begin
            @(negedge i_Clk);
            n++;
        end
        check({tag, " rx arrival"}, 32'(o_Rx_Empty), 32'd0);
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 500) begin
            @(negedge i_Clk);
            n++;
        end
        check({tag, " done count"}, done_cnt, target);
    endtask

    int t_wr, base_dv, base_done, base_log, base_rx, base_rise, base_fall;
    int f_fall, f_dv1, f_dv2, f_rise, f_dvn, n;

    initial begin
        // Reset
        tick(3);
        check("rst cs_n", 32'(o_SPI_CS_n), 32'd1);
        check("rst tx_count", 32'(o_Tx_Count), 32'd0);
        check("rst rx_empty", 32'(o_Rx_Empty), 32'd1);
        check("rst busy", 32'(o_Busy), 32'd0);
        check("rst tx_full", 32'(o_Tx_Full), 32'd0);
        check("rst rx_ovf", 32'(o_Rx_Ovf), 32'd0);
        check("rst done", 32'(o_Done), 32'd0);
        check("rst tx_dv", 32'(o_TX_DV), 32'd0);
        check("rst tx_byte", 32'(o_TX_Byte), 32'd0);
        check("rst rd_data", 32'(o_Rd_Data), 32'd0);
        rstn = 1'b1;
        tick(2);

        // Single two-byte frame, then a write during GAP to start the next frame
        base_dv = dv_cnt; base_done = done_cnt; base_log = tx_log.size(); base_rx = rxdv_t.size();
        t_wr = cyc;
        write_byte(8'hA5);
        check("frame count after 1 write", 32'(o_Tx_Count), 32'd1);
        write_byte(8'h3C);
        check("frame count after 2 writes", 32'(o_Tx_Count), 32'd2);
        wait_rx("frame b0");
        check("frame rx b0", 32'(o_Rd_Data), 32'hA5);
        read_byte();
        wait_rx("frame b1");
        check("frame rx b1", 32'(o_Rd_Data), 32'h3C);
        read_byte();
        wait_done(base_done + 1, "frame");
        f_fall = t_fall; f_dv1 = t_dv_first; f_dv2 = t_dv_last; f_rise = t_rise; f_dvn = dv_cnt - base_dv;
        base_fall = fall_cnt;
        write_byte(8'h5A);
        check("frame cs fall after write", f_fall - t_wr, 32'd2);
        check("frame setup cs->dv", f_dv1 - f_fall, SETUP + 1);
        check("frame dv pulses", f_dvn, 32'd2);
        check("frame tx b0", 32'(tx_log[base_log]), 32'hA5);
        check("frame tx b1", 32'(tx_log[base_log + 1]), 32'h3C);
        check("frame back-to-back dv", f_dv2 - rxdv_t[base_rx], 32'd2);
        check("frame hold rxdv->cs rise", f_rise - rxdv_t[base_rx + 1], HOLD + 2);
        check("frame cs_n after done", 32'(o_SPI_CS_n), 32'd1);
        n = 0;
        while (fall_cnt == base_fall && n < 50) begin
            tick(1);
            n++;
        end
        check("gap next frame started", fall_cnt, base_fall + 1);
        check("gap cs high time", t_fall - f_rise, GAP + 1);
        wait_rx("gap frame");
        check("gap frame rx", 32'(o_Rd_Data), 32'h5A);
        read_byte();
        wait_done(base_done + 2, "gap frame");

        // TX FIFO full with the engine stalled
        eng_stall = 1'b1;
        tick(2);
        base_dv = dv_cnt; base_done = done_cnt; base_log = tx_log.size();
        for (int i = 0; i < DEPTH + 2; i++)
            write_byte(8'h10 + 8'(i));
        check("full tx_count", 32'(o_Tx_Count), DEPTH);
        check("full tx_full", 32'(o_Tx_Full), 32'd1);
        check("full no dv while stalled", dv_cnt - base_dv, 32'd0);
        check("full busy", 32'(o_Busy), 32'd1);
        eng_stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wait_rx($sformatf("full b%0d", i));
            check($sformatf("full rx b%0d", i), 32'(o_Rd_Data), 32'h10 + i);
            read_byte();
        end
        wait_done(base_done + 1, "full");
        check("full bytes sent", tx_log.size() - base_log, DEPTH);
        check("full tx_count drained", 32'(o_Tx_Count), 32'd0);
        check("full tx_full cleared", 32'(o_Tx_Full), 32'd0);
        check("full rx_empty", 32'(o_Rx_Empty), 32'd1);
        check("full no ovf", 32'(o_Rx_Ovf), 32'd0);

        // Hold CS across a drained FIFO
        i_Hold_CS = 1'b1;
        base_done = done_cnt; base_rise = rise_cnt; base_dv = dv_cnt;
        write_byte(8'h77);
        wait_rx("hold b0");
        check("hold rx b0", 32'(o_Rd_Data), 32'h77);
        read_byte();
        tick(100);
        check("hold cs_n low", 32'(o_SPI_CS_n), 32'd0);
        check("hold busy", 32'(o_Busy), 32'd1);
        check("hold no done", done_cnt, base_done);
        check("hold one dv", dv_cnt - base_dv, 32'd1);
        write_byte(8'h88);
        wait_rx("hold b1");
        check("hold rx b1", 32'(o_Rd_Data), 32'h88);
        read_byte();
        check("hold same frame", rise_cnt, base_rise);
        check("hold two dv", dv_cnt - base_dv, 32'd2);
        i_Hold_CS = 1'b0;
        wait_done(base_done + 1, "hold release");
        check("hold cs_n high", 32'(o_SPI_CS_n), 32'd1);

        // RX overflow: DEPTH+1 bytes received with no reads
        base_done = done_cnt;
        for (int i = 0; i < DEPTH; i++)
            write_byte(8'h40 + 8'(i));
        n = 0;
        while (o_Tx_Full === 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        write_byte(8'h40 + 8'(DEPTH));
        wait_done(base_done + 1, "ovf");
        check("ovf set", 32'(o_Rx_Ovf), 32'd1);
`ifdef SPI_SEQ_RX_FIFO_EN
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ovf rx b%0d", i), 32'(o_Rd_Data), 32'h40 + i);
            read_byte();
        end
`else
        check("ovf rx_empty", 32'(o_Rx_Empty), 32'd0);
        check("ovf last byte kept", 32'(o_Rd_Data), 32'h40 + DEPTH);
        read_byte();
`endif
        check("ovf drained", 32'(o_Rx_Empty), 32'd1);
        read_byte();
        check("ovf read on empty", 32'(o_Rx_Empty), 32'd1);
        check("ovf still sticky", 32'(o_Rx_Ovf), 32'd1);
        i_Clr_Ovf = 1'b1;
        tick(1);
        i_Clr_Ovf = 1'b0;
        check("ovf cleared", 32'(o_Rx_Ovf), 32'd0);

        // Reset in the middle of a byte
        base_done = done_cnt; base_dv = dv_cnt;
        write_byte(8'h99);
        write_byte(8'hAA);
        n = 0;
        while (dv_cnt == base_dv && n < 50) begin
            tick(1);
            n++;
        end
        check("midrst dv issued", dv_cnt - base_dv, 32'd1);
        tick(5);
        check("midrst tx_count before", 32'(o_Tx_Count), 32'd1);
        check("midrst busy before", 32'(o_Busy), 32'd1);
        rstn = 1'b0;
        tick(1);
        check("midrst cs_n", 32'(o_SPI_CS_n), 32'd1);
        check("midrst tx_count", 32'(o_Tx_Count), 32'd0);
        check("midrst rx_empty", 32'(o_Rx_Empty), 32'd1);
        check("midrst busy", 32'(o_Busy), 32'd0);
        check("midrst tx_dv", 32'(o_TX_DV), 32'd0);
        tick(2);
        rstn = 1'b1;
        tick(60);
        check("midrst no done", done_cnt, base_done);
        check("midrst no new dv", dv_cnt - base_dv, 32'd1);
        check("midrst cs_n idle", 32'(o_SPI_CS_n), 32'd1);
        check("midrst rx still empty", 32'(o_Rx_Empty), 32'd1);

        check("engine protocol violations", viol, 32'd0);
        check("done without cs rise", bad_done, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
